// File: rtl/mii_tx_arbiter_pkg.sv
// Shared constants and types for the two-requester MII transmit arbiter.
// Holds the FSM encoding, the preamble/SFD/jam nibble values and the default frame-gap lengths.
package mii_tx_arbiter_pkg;

    localparam int unsigned MiiDataWidth    = 4;
    localparam int unsigned DefIfgNibbles   = 24;
    localparam int unsigned DefJamNibbles   = 8;
    localparam int unsigned PreambleNibbles = 15;

    localparam logic [MiiDataWidth-1:0] PreambleNibble = 4'h5;
    localparam logic [MiiDataWidth-1:0] SfdNibble      = 4'hD;
    localparam logic [MiiDataWidth-1:0] JamNibble      = 4'h5;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StDataLo,
        StDataHi,
        StJam,
        StIfg
    } tx_state_e;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mii_rr_arbiter.sv
// Two-way round-robin grant. The priority pointer only moves when the grant is taken,
// so it advances once per frame rather than once per byte.
module mii_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_idx_o = 1'b0;
        if (req_i == 2'b11) begin
            gnt_idx_o = prio_q;
        end else if (req_i == 2'b10) begin
            gnt_idx_o = 1'b1;
        end
        gnt_o  = (|req_i) ? (2'b01 << gnt_idx_o) : 2'b00;
        prio_d = advance_i ? ~gnt_idx_o : prio_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mii_tx_arbiter.sv
// MII transmitter shared by two byte-stream requesters: preamble/SFD framing, nibble
// serialisation, collision/underrun jam and inter-frame gap.
module mii_tx_arbiter
    import mii_tx_arbiter_pkg::*;
#(
    parameter int unsigned IFG_NIBBLES = DefIfgNibbles,
    parameter int unsigned JAM_NIBBLES = DefJamNibbles
) (
    input  logic                    i_tx_clk,
    input  logic                    i_rst,
    input  logic [1:0]              i_req_valid,
    input  logic [7:0]              i_req_data0,
    input  logic [7:0]              i_req_data1,
    input  logic [1:0]              i_req_last,
    output logic [1:0]              o_req_ready,
    output logic [1:0]              o_req_done,
    output logic [1:0]              o_req_abort,
    input  logic                    i_mii_crs,
    input  logic                    i_mii_col,
    output logic                    o_mii_tx_en,
    output logic                    o_mii_tx_er,
    output logic [MiiDataWidth-1:0] o_mii_tx_data,
    output logic                    o_busy
);

    localparam int unsigned CntW = $clog2(max3(PreambleNibbles, JAM_NIBBLES, IFG_NIBBLES) + 1);

    tx_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic last_q, last_d;
    logic sel_q, sel_d;
    logic jam_er_q, jam_er_d;
    logic [1:0] done_q, done_d, abort_q, abort_d;
    logic tx_en_q, tx_en_d, tx_er_q, tx_er_d, busy_q;
    logic [MiiDataWidth-1:0] tx_data_q, tx_data_d;

    logic [1:0] gnt;
    logic       gnt_idx;
    logic       start, more_ok, in_frame, sel_valid, sel_last;
    logic [7:0] sel_data;

    assign start     = (state_q == StIdle) && !i_mii_crs && (|i_req_valid) && !i_rst;
    assign in_frame  = state_q inside {StPreamble, StSfd, StDataLo, StDataHi};
    assign more_ok   = (state_q == StDataHi) && !last_q && !i_mii_col && !i_rst;
    assign sel_valid = i_req_valid[sel_q];
    assign sel_last  = i_req_last[sel_q];
    assign sel_data  = sel_q ? i_req_data1 : i_req_data0;

    mii_rr_arbiter u_rr_arbiter (
        .clk_i     (i_tx_clk),
        .rst_i     (i_rst),
        .req_i     (i_req_valid),
        .advance_i (start),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        o_req_ready = 2'b00;
        if (start) begin
            o_req_ready = gnt;
        end else if (more_ok) begin
            o_req_ready[sel_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        byte_d   = byte_q;
        last_d   = last_q;
        sel_d    = sel_q;
        jam_er_d = jam_er_q;
        done_d   = 2'b00;
        abort_d  = 2'b00;
        if (in_frame && i_mii_col) begin
            state_d          = StJam;
            abort_d[sel_q]   = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d  = StPreamble;
                        sel_d    = gnt_idx;
                        byte_d   = gnt_idx ? i_req_data1 : i_req_data0;
                        last_d   = i_req_last[gnt_idx];
                        jam_er_d = 1'b0;
                    end
                end
                StPreamble: if (cnt_q == CntW'(PreambleNibbles - 1)) state_d = StSfd;
                StSfd:      state_d = StDataLo;
                StDataLo:   state_d = StDataHi;
                StDataHi: begin
                    if (last_q) begin
                        state_d        = StIfg;
                        done_d[sel_q]  = 1'b1;
                    end else if (sel_valid) begin
                        state_d = StDataLo;
                        byte_d  = sel_data;
                        last_d  = sel_last;
                    end else begin
                        // Underrun: jam is flagged with tx_er, unlike a collision jam.
                        state_d        = StJam;
                        jam_er_d       = 1'b1;
                        abort_d[sel_q] = 1'b1;
                    end
                end
                StJam: if (cnt_q == CntW'(JAM_NIBBLES - 1)) state_d = StIfg;
                StIfg: if (cnt_q == CntW'(IFG_NIBBLES - 1)) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
        if (state_d != state_q || state_q == StIdle) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        tx_data_d = '0;
        case (state_d)
            StPreamble: begin tx_en_d = 1'b1; tx_data_d = PreambleNibble; end
            StSfd:      begin tx_en_d = 1'b1; tx_data_d = SfdNibble; end
            StDataLo:   begin tx_en_d = 1'b1; tx_data_d = byte_d[3:0]; end
            StDataHi:   begin tx_en_d = 1'b1; tx_data_d = byte_d[7:4]; end
            StJam:      begin tx_en_d = 1'b1; tx_er_d = jam_er_d; tx_data_d = JamNibble; end
            default:    ;
        endcase
    end

    always_ff @(posedge i_tx_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            sel_q     <= 1'b0;
            jam_er_q  <= 1'b0;
            done_q    <= 2'b00;
            abort_q   <= 2'b00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            jam_er_q  <= jam_er_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            tx_data_q <= tx_data_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign o_req_done    = done_q;
    assign o_req_abort   = abort_q;
    assign o_mii_tx_en   = tx_en_q;
    assign o_mii_tx_er   = tx_er_q;
    assign o_mii_tx_data = tx_data_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: requester byte queues feed the DUT, and the expected
// MII nibble stream is queued up front and popped whenever tx_en is high.
module tb_mii_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_last, req_ready, req_done, req_abort;
    logic [7:0] req_data0, req_data1;
    logic       mii_crs, mii_col, tx_en, tx_er, busy;
    logic [3:0] tx_data;

    always #5 clk = ~clk;

    mii_tx_arbiter dut (
        .i_tx_clk      (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .i_req_data0   (req_data0),
        .i_req_data1   (req_data1),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_req_done    (req_done),
        .o_req_abort   (req_abort),
        .i_mii_crs     (mii_crs),
        .i_mii_col     (mii_col),
        .o_mii_tx_en   (tx_en),
        .o_mii_tx_er   (tx_er),
        .o_mii_tx_data (tx_data),
        .o_busy        (busy)
    );

    typedef struct packed {
        logic       er;
        logic [3:0] d;
    } nib_t;

    nib_t       exp_q[$];
    logic [8:0] src0[$];
    logic [8:0] src1[$];
    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt, quiet_cnt, pre_cnt;
    int done_cnt[2];
    int abort_cnt[2];
    int col_at = -1;
    logic [1:0] xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_nib(input logic er, input logic [3:0] d);
        nib_t n;
        n.er = er;
        n.d  = d;
        exp_q.push_back(n);
    endtask

    task automatic push_pre();
        repeat (15) push_nib(1'b0, 4'h5);
        push_nib(1'b0, 4'hD);
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_nib(1'b0, b[3:0]);
        push_nib(1'b0, b[7:4]);
    endtask

    task automatic push_jam(input logic er);
        repeat (8) push_nib(er, 4'h5);
    endtask

    task automatic drive_inputs();
        req_valid[0] = (src0.size() != 0);
        req_data0    = (src0.size() != 0) ? src0[0][7:0] : 8'h00;
        req_last[0]  = (src0.size() != 0) ? src0[0][8] : 1'b0;
        req_valid[1] = (src1.size() != 0);
        req_data1    = (src1.size() != 0) ? src1[0][7:0] : 8'h00;
        req_last[1]  = (src1.size() != 0) ? src1[0][8] : 1'b0;
    endtask

    task automatic clear_counts();
        en_cnt       = 0;
        quiet_cnt    = 0;
        done_cnt[0]  = 0;
        done_cnt[1]  = 0;
        abort_cnt[0] = 0;
        abort_cnt[1] = 0;
    endtask

    task automatic tick();
        nib_t e;
        logic [8:0] dummy;
        @(negedge clk);
        xfer = req_ready & req_valid;
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        @(posedge clk);
        #1;
        if (xfer[0] && src0.size() != 0) dummy = src0.pop_front();
        if (xfer[1] && src1.size() != 0) dummy = src1.pop_front();
        drive_inputs();
        if (tx_en) begin
            en_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_tx", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.d));
                check("tx_er", 32'(tx_er), 32'(e.er));
            end
        end else begin
            check("tx_er_idle", 32'(tx_er), 32'd0);
            if (busy) quiet_cnt++;
        end
        done_cnt[0]  += int'(req_done[0]);
        done_cnt[1]  += int'(req_done[1]);
        abort_cnt[0] += int'(req_abort[0]);
        abort_cnt[1] += int'(req_abort[1]);
        mii_col = (en_cnt == col_at);
    endtask

    // Runs until the DUT has been busy and returned to IDLE; pre_cnt = idle cycles before start.
    task automatic run_frame(input string tag);
        bit fin;
        int pre;
        bit started;
        fin     = 1'b0;
        pre     = 0;
        started = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (busy) begin
                started = 1'b1;
            end else if (started) begin
                fin = 1'b1;
                break;
            end else begin
                pre++;
            end
        end
        check({tag, "_ended"}, 32'(fin), 32'd1);
        check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        pre_cnt = pre;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        mii_crs   = 1'b0;
        mii_col   = 1'b0;
        clear_counts();

        do_reset();
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_er", 32'(tx_er), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_abort", 32'(req_abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Basic three-byte frame from requester 0.
        clear_counts();
        src0.push_back({1'b0, 8'hA1});
        src0.push_back({1'b0, 8'hB2});
        src0.push_back({1'b1, 8'hC3});
        push_pre();
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        run_frame("basic");
        check("basic_en_cycles", 32'(en_cnt), 32'd22);
        check("basic_ifg_cycles", 32'(quiet_cnt), 32'd24);
        check("basic_done0", 32'(done_cnt[0]), 32'd1);
        check("basic_done1", 32'(done_cnt[1]), 32'd0);
        check("basic_abort", 32'(abort_cnt[0] + abort_cnt[1]), 32'd0);

        // Contention right after reset: requester 0 first, then requester 1 straight after IFG.
        do_reset();
        clear_counts();
        src0.push_back({1'b0, 8'h11});
        src0.push_back({1'b1, 8'h22});
        src1.push_back({1'b1, 8'h33});
        push_pre();
        push_byte(8'h11);
        push_byte(8'h22);
        run_frame("rr_a");
        check("rr_a_done0", 32'(done_cnt[0]), 32'd1);
        check("rr_a_done1", 32'(done_cnt[1]), 32'd0);
        clear_counts();
        push_pre();
        push_byte(8'h33);
        run_frame("rr_b");
        check("rr_b_start_delay", 32'(pre_cnt), 32'd0);
        check("rr_b_done1", 32'(done_cnt[1]), 32'd1);
        check("rr_b_en_cycles", 32'(en_cnt), 32'd18);

        // Collision on the third data nibble: plain jam (tx_er low), abort, then IFG.
        clear_counts();
        src0.push_back({1'b0, 8'h5A});
        src0.push_back({1'b0, 8'h6B});
        src0.push_back({1'b1, 8'h7C});
        col_at = 19;
        push_pre();
        push_nib(1'b0, 4'hA);
        push_nib(1'b0, 4'h5);
        push_nib(1'b0, 4'hB);
        push_jam(1'b0);
        run_frame("col");
        src0.delete();
        drive_inputs();
        col_at  = -1;
        mii_col = 1'b0;
        check("col_en_cycles", 32'(en_cnt), 32'd27);
        check("col_ifg_cycles", 32'(quiet_cnt), 32'd24);
        check("col_abort0", 32'(abort_cnt[0]), 32'd1);
        check("col_done0", 32'(done_cnt[0]), 32'd0);

        // Requester 1 underrun after its first byte: jam with tx_er high.
        clear_counts();
        src1.push_back({1'b0, 8'h9E});
        push_pre();
        push_byte(8'h9E);
        push_jam(1'b1);
        run_frame("underrun");
        check("ur_en_cycles", 32'(en_cnt), 32'd26);
        check("ur_ifg_cycles", 32'(quiet_cnt), 32'd24);
        check("ur_abort1", 32'(abort_cnt[1]), 32'd1);
        check("ur_done1", 32'(done_cnt[1]), 32'd0);

        // Carrier sense defers the start; transmission begins the cycle after crs falls.
        clear_counts();
        mii_crs = 1'b1;
        src0.push_back({1'b1, 8'h42});
        drive_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            check("crs_ready", 32'(req_ready), 32'd0);
            check("crs_tx_en", 32'(tx_en), 32'd0);
            check("crs_busy", 32'(busy), 32'd0);
        end
        mii_crs = 1'b0;
        push_pre();
        push_byte(8'h42);
        run_frame("crs");
        check("crs_start_delay", 32'(pre_cnt), 32'd0);
        check("crs_done0", 32'(done_cnt[0]), 32'd1);

        // Reset in the middle of data: immediate truncation without pulses.
        clear_counts();
        src0.push_back({1'b0, 8'h01});
        src0.push_back({1'b0, 8'h02});
        src0.push_back({1'b1, 8'h03});
        push_pre();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        begin
            bit reached;
            reached = 1'b0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (en_cnt == 18) begin
                    reached = 1'b1;
                    break;
                end
            end
            check("mid_reached", 32'(reached), 32'd1);
        end
        rst = 1'b1;
        tick();
        check("mid_rst_tx_en", 32'(tx_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
        check("mid_rst_abort", 32'(abort_cnt[0] + abort_cnt[1]), 32'd0);
        src0.delete();
        exp_q.delete();
        drive_inputs();
        tick();
        check("mid_rst_hold_tx_en", 32'(tx_en), 32'd0);
        rst = 1'b0;

        // Reset must also return the round-robin pointer to requester 0.
        clear_counts();
        src0.push_back({1'b1, 8'h55});
        src1.push_back({1'b1, 8'h66});
        push_pre();
        push_byte(8'h55);
        run_frame("ptr_a");
        check("ptr_a_done0", 32'(done_cnt[0]), 32'd1);
        check("ptr_a_done1", 32'(done_cnt[1]), 32'd0);
        clear_counts();
        push_pre();
        push_byte(8'h66);
        run_frame("ptr_b");
        check("ptr_b_done1", 32'(done_cnt[1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mii_tx_arbiter.md
MII_TX_ARBITER -- requirements
Module: mii_tx_arbiter

Interface
REQ-001 Parameter IFG_NIBBLES, default 24, minimum idle nibble clocks between frames (96 bit times).
REQ-002 Parameter JAM_NIBBLES, default 8, jam length in nibbles after collision (32 bits).
REQ-003 i_tx_clk  input  1  MII TX clock; sole clock of the block.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_req_valid  input  2  per-requester byte valid; bit n = requester n.
REQ-006 i_req_data0, i_req_data1  input  8 each  byte from requester 0/1.
REQ-007 i_req_last  input  2  per-requester marker: current byte is final byte of frame.
REQ-008 o_req_ready  output  2  per-requester byte accept; a byte transfers when valid&ready.
REQ-009 o_req_done  output  2  one-cycle pulse: frame of requester n fully sent.
REQ-010 o_req_abort  output  2  one-cycle pulse: frame of requester n aborted (collision or underrun).
REQ-011 i_mii_crs, i_mii_col  input  1 each  carrier sense / collision from PHY.
REQ-012 o_mii_tx_en, o_mii_tx_er  output  1 each  MII transmit enable / error.
REQ-013 o_mii_tx_data  output  `MII_DATA_WIDTH  transmit nibble.
REQ-014 o_busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, JAM, IFG; all outputs registered.
REQ-016 IDLE: when i_mii_crs=0 and any i_req_valid set, grant one requester, assert its o_req_ready that cycle, latch byte and last flag, go PREAMBLE.
REQ-017 Arbitration round-robin: on contention, grant the requester not granted last; after reset requester 0 has priority.
REQ-018 i_mii_crs=1 in IDLE defers start; no ready asserted.
REQ-019 PREAMBLE: 15 nibbles 0x5 with tx_en=1, then SFD: one nibble 0xD.
REQ-020 DATA_LO drives latched byte[3:0]; DATA_HI drives byte[7:4]; tx_en=1 throughout.
REQ-021 In DATA_HI, if latched last=0, o_req_ready of granted requester is 1; with valid=1 the next byte latches and FSM returns to DATA_LO.
REQ-022 In DATA_HI with latched last=0 and valid=0 (underrun): go JAM, tx_er=1 during jam, pulse o_req_abort.
REQ-023 In DATA_HI with latched last=1: o_req_ready=0, pulse o_req_done, go IFG.
REQ-024 i_mii_col=1 in PREAMBLE, SFD, DATA_LO or DATA_HI: next state JAM, pulse o_req_abort; no retry.
REQ-025 JAM: JAM_NIBBLES nibbles 0x5 with tx_en=1, then IFG; i_mii_col ignored in JAM.
REQ-026 IFG: tx_en=0, data=0 for IFG_NIBBLES cycles, then IDLE; requests ignored.
REQ-027 o_req_ready never asserted for the non-granted requester; at most one bit of o_req_ready set.
REQ-028 Nibble counter width ceil(log2(max(15, JAM_NIBBLES, IFG_NIBBLES)+1)); clears on every state entry.
REQ-029 Frame payload length unbounded; preamble-to-first-data latency 16 clocks after grant.

Reset
REQ-030 i_rst=1 at a clock edge: state IDLE, tx_en=0, tx_er=0, tx_data=0, ready/done/abort=0, busy=0, round-robin pointer to requester 0.
REQ-031 Reset mid-frame truncates immediately with no jam and no done/abort pulse.

Structure
REQ-032 FSM state encoding, preamble/SFD nibble constants and default IFG/jam lengths in shared defines.v alongside MII_DATA_WIDTH.
REQ-033 Round-robin grant logic as sub-module mii_rr_arbiter (2 requesters, grant-on-frame-boundary).

Verification
REQ-034 Req0 sends 3 bytes 0xA1,0xB2,0xC3 -> tx_en for 22 cycles: 15x5, D, 1,A,2,B,3,C; done[0] pulse; 24 idle cycles.
REQ-035 Both valid in IDLE after reset -> req0 frame first, req1 granted at first IDLE after req0 IFG.
REQ-036 i_mii_col pulsed on 3rd data nibble -> abort pulse, 8 nibbles 0x5 with tx_er=0, then IFG.
REQ-037 Req1 drops valid before 2nd byte, last=0 -> jam with tx_er=1, abort[1] pulse.
REQ-038 i_mii_crs high while req0 valid -> no ready, tx_en stays 0 until crs falls; start next cycle.
REQ-039 i_rst asserted mid-DATA -> next cycle tx_en=0, busy=0, no done/abort pulse.
